topk_stream_sorter: RTL

- Parametrised successor to the KNN in-memory bubble sorter. Accepts a stream of num_i tagged distances and keeps the best k_i entries in a register-based insertion array, one element per cycle.
- Streams the k_i winners out in order over a valid/ready handshake, then returns to idle for the next query.
- Adds runtime K, ascending/descending mode, signed keys, stable tie order and back-pressure. Sits between the distance units and the voting stage.

---
 rtl/knn_pkg.sv | 51 +++++
 rtl/topk_slot.sv | 56 +++++
 rtl/topk_stream_sorter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: shared types and helpers for the top-K sorter and the distance units.
//   state_t    - sorter control states
//   slot_op_t  - per-slot update select (hold / insert new / take upper / take lower)
//   elem_t     - {tag,key} element at the default widths
//   key_better - ordering predicate used for insertion
package knn_pkg;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_FIN} state_t;

    typedef enum logic [1:0] {OP_HOLD, OP_INS, OP_SHDN, OP_SHUP} slot_op_t;

    localparam int TAG_DEF     = 2;
    localparam int WIDTH_DEF   = 4;
    localparam int K_MAX_DEF   = 8;
    localparam int MAX_NUM_DEF = 1024;
    localparam int NUM_W_DEF   = $clog2(MAX_NUM_DEF + 1);
    localparam int K_W_DEF     = $clog2(K_MAX_DEF + 1);
    localparam int KEY_CMP_W   = 32;

    typedef logic [TAG_DEF+WIDTH_DEF-1:0] elem_t;

    // True when key a should be placed ahead of key b. Keys arrive
    // zero-extended to KEY_CMP_W; left-justifying them puts the key MSB in
    // the sign position so one signed or unsigned compare covers any width.
    // Equal keys are never better, which keeps earlier arrivals ahead.
    function automatic logic key_better(input logic [KEY_CMP_W-1:0] a,
                                        input logic [KEY_CMP_W-1:0] b,
                                        input int unsigned          width,
                                        input logic                 mode,
                                        input logic                 signed_key);
        logic signed [KEY_CMP_W-1:0] a_s;
        logic signed [KEY_CMP_W-1:0] b_s;
        logic [KEY_CMP_W-1:0]        a_u;
        logic [KEY_CMP_W-1:0]        b_u;
        logic                        lt;
        logic                        gt;
        a_u = a << (KEY_CMP_W - width);
        b_u = b << (KEY_CMP_W - width);
        a_s = $signed(a_u);
        b_s = $signed(b_u);
        if (signed_key) begin
            lt = a_s < b_s;
            gt = a_s > b_s;
        end else begin
            lt = a_u < b_u;
            gt = a_u > b_u;
        end
        return mode ? gt : lt;
    endfunction

endpackage

// File: rtl/topk_slot.sv
// topk_slot: one entry of the insertion array (element register + valid bit).
//   clk_i, rst_i  clock, synchronous active-low reset (clears valid only)
//   clr_i         clear valid at query start
//   op_i          hold / load new_i / take prev_* (shift down) / take next_* (shift up)
//   new_i         incoming element
//   prev_*        neighbour above (index-1), next_* neighbour below (index+1)
//   better_i      incoming key beats this slot's key
//   data_o/valid_o  slot contents; cand_o = slot would accept the new element
module topk_slot
    import knn_pkg::*;
#(
    parameter int EW = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  slot_op_t      op_i,
    input  logic [EW-1:0] new_i,
    input  logic [EW-1:0] prev_i,
    input  logic          prev_v_i,
    input  logic [EW-1:0] next_i,
    input  logic          next_v_i,
    input  logic          better_i,
    output logic [EW-1:0] data_o,
    output logic          valid_o,
    output logic          cand_o
);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_o <= 1'b0;
        end else if (clr_i) begin
            valid_o <= 1'b0;
        end else begin
            case (op_i)
                OP_INS:  valid_o <= 1'b1;
                OP_SHDN: valid_o <= prev_v_i;
                OP_SHUP: valid_o <= next_v_i;
                default: valid_o <= valid_o;
            endcase
        end
    end

    // Data is qualified by valid_o, so it needs no reset.
    always_ff @(posedge clk_i) begin
        case (op_i)
            OP_INS:  data_o <= new_i;
            OP_SHDN: data_o <= prev_i;
            OP_SHUP: data_o <= next_i;
            default: data_o <= data_o;
        endcase
    end

    assign cand_o = !valid_o || better_i;

endmodule

// File: rtl/topk_stream_sorter.sv
// topk_stream_sorter: keeps the best k entries of a tagged distance stream in
// a register insertion array, then streams them out best-first.
//   clk_i, rst_i (sync, active-low)
//   start_i, num_i, k_i, mode_i : query setup, latched in IDLE
//   busy_o                      : high outside IDLE
//   in_v_i, in_data_i, in_ready_o : element input handshake ({tag,key})
//   out_v_o, out_data_o, out_last_o, out_ready_i : result handshake
//   done_o                      : one-cycle pulse at query end
module topk_stream_sorter
    import knn_pkg::*;
#(
    parameter int TAG        = 2,
    parameter int WIDTH      = 4,
    parameter int K_MAX      = 8,
    parameter int MAX_NUM    = 1024,
    parameter int SIGNED_KEY = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [$clog2(MAX_NUM+1)-1:0]     num_i,
    input  logic [$clog2(K_MAX+1)-1:0]       k_i,
    input  logic                             mode_i,
    output logic                             busy_o,
    input  logic                             in_v_i,
    input  logic [TAG+WIDTH-1:0]             in_data_i,
    output logic                             in_ready_o,
    output logic                             out_v_o,
    output logic [TAG+WIDTH-1:0]             out_data_o,
    output logic                             out_last_o,
    input  logic                             out_ready_i,
    output logic                             done_o
);

    localparam int EW    = TAG + WIDTH;
    localparam int NUM_W = $clog2(MAX_NUM + 1);
    localparam int KW    = $clog2(K_MAX + 1);

    state_t           state_q, state_d;
    logic [NUM_W-1:0] num_q, cnt_q;
    logic [KW-1:0]    k_q, k_eff;
    logic             mode_q;

    // Index K_MAX is a permanently empty sentinel feeding the last slot on drain.
    logic [EW-1:0]    slot_data [K_MAX+1];
    logic             slot_v    [K_MAX+1];
    logic             better    [K_MAX];
    logic             cand      [K_MAX];
    slot_op_t         ops       [K_MAX];

    logic             hs_in, hs_out, start_go, found;
    logic [KW-1:0]    pos;

    assign slot_data[K_MAX] = '0;
    assign slot_v[K_MAX]    = 1'b0;

    assign k_eff    = (k_i > KW'(K_MAX)) ? KW'(K_MAX) : k_i;
    assign start_go = (state_q == S_IDLE) && start_i;
    assign hs_in    = in_v_i && in_ready_o;
    assign hs_out   = out_v_o && out_ready_i;

    for (genvar i = 0; i < K_MAX; i++) begin : g_slot
        logic [EW-1:0] prev_d;
        logic          prev_v;
        if (i == 0) begin : g_first
            assign prev_d = in_data_i;
            assign prev_v = 1'b0;
        end else begin : g_rest
            assign prev_d = slot_data[i-1];
            assign prev_v = slot_v[i-1];
        end

        assign better[i] = key_better(KEY_CMP_W'(in_data_i[WIDTH-1:0]),
                                      KEY_CMP_W'(slot_data[i][WIDTH-1:0]),
                                      WIDTH, mode_q, SIGNED_KEY != 0);

        topk_slot #(.EW(EW)) u_slot (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clr_i    (start_go),
            .op_i     (ops[i]),
            .new_i    (in_data_i),
            .prev_i   (prev_d),
            .prev_v_i (prev_v),
            .next_i   (slot_data[i+1]),
            .next_v_i (slot_v[i+1]),
            .better_i (better[i]),
            .data_o   (slot_data[i]),
            .valid_o  (slot_v[i]),
            .cand_o   (cand[i])
        );
    end

    // Lowest slot below k_eff that is empty or holds a worse key.
    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = K_MAX - 1; i >= 0; i--) begin
            if (cand[i] && (KW'(i) < k_q)) begin
                found = 1'b1;
                pos   = KW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < K_MAX; i++) begin
            ops[i] = OP_HOLD;
            if (hs_in && found) begin
                if (KW'(i) == pos)
                    ops[i] = OP_INS;
                else if ((KW'(i) > pos) && (KW'(i) < k_q))
                    ops[i] = OP_SHDN;
            end else if (hs_out) begin
                ops[i] = OP_SHUP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_go) begin
                num_q  <= num_i;
                k_q    <= k_eff;
                mode_q <= mode_i;
                cnt_q  <= '0;
            end else if (hs_in) begin
                cnt_q <= cnt_q + NUM_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        busy_o     = 1'b1;
        in_ready_o = 1'b0;
        out_v_o    = 1'b0;
        out_data_o = '0;
        out_last_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i)
                    state_d = ((num_i == '0) || (k_eff == '0)) ? S_FIN : S_FILL;
            end
            S_FILL: begin
                in_ready_o = 1'b1;
                if (hs_in && ((cnt_q + NUM_W'(1)) == num_q))
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                out_v_o = slot_v[0];
                if (slot_v[0]) begin
                    out_data_o = slot_data[0];
                    out_last_o = !slot_v[1] || (k_q == KW'(1));
                end
                if (hs_out && out_last_o)
                    state_d = S_FIN;
            end
            S_FIN: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
